// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
//   Iterative RV32M divider (DIV / DIVU / REM / REMU), one restoring
//   quotient bit per clock. Stalls the core through busy while working and
//   presents result / rd_out / reg_write for exactly one cycle on done.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   start      request, accepted only while idle
//   op         00 DIV, 01 DIVU, 10 REM, 11 REMU
//   rs1_data   dividend
//   rs2_data   divisor
//   rd_in      destination register index
//   busy       high while calculating and in the done cycle
//   done       one-cycle pulse, result and rd_out valid
//   result     quotient or remainder (held until the next completion/reset)
//   rd_out     destination index latched at accept
//   reg_write  done && (rd_out != 0)
// ---------------------------------------------------------------------------
module div_unit #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [WIDTH-1:0]      rs1_data,
    input  logic [WIDTH-1:0]      rs2_data,
    input  logic [REG_ADDR_W-1:0] rd_in,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      result,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic                  reg_write
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t                r_state;
    logic                  r_is_rem;
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic [WIDTH-1:0]      r_dvd;      // dividend magnitude, becomes quotient
    logic [WIDTH-1:0]      r_dvs;      // divisor magnitude
    logic [WIDTH-1:0]      r_rem;      // partial remainder
    logic [CW-1:0]         r_cnt;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_reg_write;
    logic [WIDTH-1:0]      r_result;
    logic [REG_ADDR_W-1:0] r_rd;

    // Operand decode at accept
    logic             w_signed;
    logic             w_rs1_neg;
    logic             w_rs2_neg;
    logic [WIDTH-1:0] w_abs1;
    logic [WIDTH-1:0] w_abs2;
    logic             w_div0;
    logic             w_ovf;
    logic             w_special;
    logic [WIDTH-1:0] w_special_res;

    // Restoring step
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_dvd_nx;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    always_comb begin
        w_signed  = ~op[0];
        w_rs1_neg = w_signed & rs1_data[WIDTH-1];
        w_rs2_neg = w_signed & rs2_data[WIDTH-1];
        w_abs1    = w_rs1_neg ? -rs1_data : rs1_data;
        w_abs2    = w_rs2_neg ? -rs2_data : rs2_data;
        w_div0    = (rs2_data == '0);
        w_ovf     = w_signed && (rs1_data == MIN_INT) && (rs2_data == '1);
        w_special = w_div0 | w_ovf;
        if (w_div0) begin
            w_special_res = op[1] ? rs1_data : '1;
        end else begin
            w_special_res = op[1] ? '0 : rs1_data;
        end
    end

    // The shifted remainder is below 2*divisor, so after a conditional
    // subtract it always fits back into WIDTH bits.
    always_comb begin
        w_rem_sh  = {r_rem, r_dvd[WIDTH-1]};
        w_diff    = w_rem_sh - {1'b0, r_dvs};
        w_ge      = ~w_diff[WIDTH];
        w_rem_nx  = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
        w_dvd_nx  = {r_dvd[WIDTH-2:0], w_ge};
        w_quo_fix = r_neg_q ? -w_dvd_nx : w_dvd_nx;
        w_rem_fix = r_neg_r ? -w_rem_nx : w_rem_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_is_rem    <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_reg_write <= 1'b0;
            r_result    <= '0;
            r_rd        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done      <= 1'b0;
                    r_reg_write <= 1'b0;
                    if (start) begin
                        r_is_rem <= op[1];
                        r_neg_q  <= w_rs1_neg ^ w_rs2_neg;
                        r_neg_r  <= w_rs1_neg;
                        r_dvd    <= w_abs1;
                        r_dvs    <= w_abs2;
                        r_rem    <= '0;
                        r_cnt    <= '0;
                        r_rd     <= rd_in;
                        r_busy   <= 1'b1;
                        if (w_special) begin
                            r_result    <= w_special_res;
                            r_done      <= 1'b1;
                            r_reg_write <= (rd_in != '0);
                            r_state     <= S_DONE;
                        end else begin
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_nx;
                    r_dvd <= w_dvd_nx;
                    r_cnt <= r_cnt + CW'(1);
                    // Final step result is sign-fixed on the same edge.
                    if (r_cnt == LAST_CNT) begin
                        r_result    <= r_is_rem ? w_rem_fix : w_quo_fix;
                        r_done      <= 1'b1;
                        r_reg_write <= (r_rd != '0);
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done      <= 1'b0;
                    r_reg_write <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign rd_out    = r_rd;
    assign reg_write = r_reg_write;

endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit
//   Self-checking bench for div_unit. Expected results are computed by a
//   behavioural reference (native integer divide) and queued when a request
//   is driven; they are popped and compared when done is observed.
// ---------------------------------------------------------------------------
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        reg_write;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_res_q[$];
    logic [4:0]  exp_rd_q[$];

    div_unit #(.WIDTH(32), .REG_ADDR_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .rd_in     (rd_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .rd_out    (rd_out),
        .reg_write (reg_write)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : a;
            return o[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return o[1] ? (a % b) : (a / b);
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Drives one request, queues its expectation, waits (bounded) for done.
    // Returns edges from accept to done, busy-high cycles, and a timeout flag.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int lat, output int bcnt, output logic to);
        @(negedge clk);
        start    = 1'b1;
        op       = o;
        rs1_data = a;
        rs2_data = b;
        rd_in    = rd;
        exp_res_q.push_back(ref_res(o, a, b));
        exp_rd_q.push_back(rd);
        @(negedge clk);
        start    = 1'b0;
        rs1_data = $urandom;
        rs2_data = $urandom;
        rd_in    = 5'($urandom);
        lat  = 1;
        bcnt = 0;
        to   = 1'b0;
        forever begin
            if (busy) bcnt++;
            if (done) break;
            if (lat >= 100) begin
                to = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        op = 2'b00;
        rs1_data = '0;
        rs2_data = '0;
        rd_in = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, reg_write} !== 3'b000 || result !== 32'd0 || rd_out !== 5'd0) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b wr=%b result=%h rd=%0d, required all zero",
                     busy, done, reg_write, result, rd_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_divu_basic();
        int lat, bcnt;
        logic to;
        logic [31:0] er;
        logic [4:0] erd;
        do_op(2'b01, 32'd100, 32'd7, 5'd5, lat, bcnt, to);
        er  = exp_res_q.pop_front();
        erd = exp_rd_q.pop_front();
        checks++;
        if (to) begin failures++; $display("FAIL divu_timeout: no done within bound"); end
        checks++;
        if (result !== er || er !== 32'd14) begin failures++; $display("FAIL divu_result: got %h required %h", result, er); end
        checks++;
        if (rd_out !== erd) begin failures++; $display("FAIL divu_rd: got %0d required %0d", rd_out, erd); end
        checks++;
        if (reg_write !== 1'b1) begin failures++; $display("FAIL divu_wr: got %b required 1", reg_write); end
        checks++;
        if (lat !== 33) begin failures++; $display("FAIL divu_latency: got %0d required 33", lat); end
        checks++;
        if (bcnt !== 33) begin failures++; $display("FAIL divu_busy_cycles: got %0d required 33", bcnt); end
        @(negedge clk);
        checks++;
        if ({busy, done, reg_write} !== 3'b000) begin
            failures++;
            $display("FAIL divu_after: busy/done/wr got %b required 000", {busy, done, reg_write});
        end
        checks++;
        if (result !== 32'd14 || rd_out !== 5'd5) begin
            failures++;
            $display("FAIL divu_hold: result %h rd %0d required 0000000e / 5", result, rd_out);
        end
    endtask

    task automatic test_signed();
        int lat, bcnt;
        logic to;
        logic [31:0] er;
        logic [1:0] ops[2] = '{2'b10, 2'b00};
        logic [31:0] req[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD};
        for (int i = 0; i < 2; i++) begin
            do_op(ops[i], 32'hFFFF_FFF9, 32'd2, 5'd12, lat, bcnt, to);
            er = exp_res_q.pop_front();
            void'(exp_rd_q.pop_front());
            checks++;
            if (to || result !== er || er !== req[i] || lat !== 33) begin
                failures++;
                $display("FAIL signed_op%0d: got %h lat %0d to %b, required %h lat 33", ops[i], result, lat, to, req[i]);
            end
        end
    endtask

    task automatic test_special();
        int lat, bcnt;
        logic to;
        logic [31:0] er;
        logic [1:0]  ops[4] = '{2'b00, 2'b10, 2'b11, 2'b01};
        logic [31:0] as[4]  = '{32'h8000_0000, 32'h8000_0000, 32'd123, 32'd5};
        logic [31:0] bs[4]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] req[4] = '{32'h8000_0000, 32'd0, 32'd123, 32'hFFFF_FFFF};
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], as[i], bs[i], 5'd1, lat, bcnt, to);
            er = exp_res_q.pop_front();
            void'(exp_rd_q.pop_front());
            checks++;
            if (to || result !== er || er !== req[i] || reg_write !== 1'b1) begin
                failures++;
                $display("FAIL special%0d: got %h wr %b, required %h wr 1", i, result, reg_write, req[i]);
            end
            checks++;
            if (lat !== 1) begin failures++; $display("FAIL special%0d_latency: got %0d required 1", i, lat); end
        end
    endtask

    task automatic test_restart_ignored();
        int n;
        logic [31:0] er;
        logic [4:0] erd;
        @(negedge clk);
        start = 1'b1; op = 2'b01; rs1_data = 32'd1000; rs2_data = 32'd10; rd_in = 5'd3;
        exp_res_q.push_back(ref_res(2'b01, 32'd1000, 32'd10));
        exp_rd_q.push_back(5'd3);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1; op = 2'b00; rs1_data = 32'd55; rs2_data = 32'd3; rd_in = 5'd7;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin @(negedge clk); n++; end
        er  = exp_res_q.pop_front();
        erd = exp_rd_q.pop_front();
        checks++;
        if (!done || result !== er || rd_out !== erd) begin
            failures++;
            $display("FAIL restart_first: done %b result %h rd %0d, required 1 %h %0d", done, result, rd_out, er, erd);
        end
        // request presented during the done cycle must be dropped
        start = 1'b1; op = 2'b01; rs1_data = 32'd9; rs2_data = 32'd3; rd_in = 5'd8;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL restart_ignored: busy %b done %b, required 0 0", busy, done);
        end
    endtask

    task automatic test_rd_zero();
        int lat, bcnt;
        logic to;
        logic [31:0] er;
        do_op(2'b01, 32'd50, 32'd5, 5'd0, lat, bcnt, to);
        er = exp_res_q.pop_front();
        void'(exp_rd_q.pop_front());
        checks++;
        if (to || done !== 1'b1 || reg_write !== 1'b0 || result !== er || lat !== 33) begin
            failures++;
            $display("FAIL rd_zero: done %b wr %b result %h lat %0d, required 1 0 %h 33", done, reg_write, result, lat, er);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bcnt;
        logic to;
        logic [31:0] er;
        @(negedge clk);
        start = 1'b1; op = 2'b00; rs1_data = 32'd1000; rs2_data = 32'd3; rd_in = 5'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, reg_write} !== 3'b000 || result !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid: busy %b done %b wr %b result %h, required 0 0 0 0", busy, done, reg_write, result);
        end
        do_op(2'b10, 32'hFFFF_FF9C, 32'd7, 5'd4, lat, bcnt, to);
        er = exp_res_q.pop_front();
        void'(exp_rd_q.pop_front());
        checks++;
        if (to || result !== er || lat !== 33 || rd_out !== 5'd4) begin
            failures++;
            $display("FAIL reset_recover: result %h lat %0d rd %0d, required %h 33 4", result, lat, rd_out, er);
        end
    endtask

    task automatic test_random();
        int lat, bcnt;
        logic to;
        logic [31:0] a, b, er;
        logic [1:0]  o;
        logic [4:0]  rd, erd;
        int el;
        for (int i = 0; i < 1000; i++) begin
            o  = 2'($urandom_range(0, 3));
            a  = pick();
            b  = pick();
            rd = 5'($urandom);
            el = ref_lat(o, a, b);
            do_op(o, a, b, rd, lat, bcnt, to);
            er  = exp_res_q.pop_front();
            erd = exp_rd_q.pop_front();
            checks++;
            if (to || result !== er || rd_out !== erd || reg_write !== (erd != 5'd0) || lat !== el) begin
                failures++;
                $display("FAIL random%0d op %0d %h/%h: result %h rd %0d wr %b lat %0d, required %h %0d %b %0d",
                         i, o, a, b, result, rd_out, reg_write, lat, er, erd, (erd != 5'd0), el);
            end
        end
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_signed();
        test_special();
        test_restart_ignored();
        test_rd_zero();
        test_reset_mid();
        test_random();
        checks++;
        if (exp_res_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_res_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
